// File: rtl/ifetch_stage.sv
// LEGv8 fetch stage: owns the PC, issues one variable-latency imem read at a time and buffers {instr, pc} for decode.
// Define IFETCH_SKID_EN to widen the output buffer from one register to a 2-entry FIFO.
module ifetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic {IDLE, REQ} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] addr_q, addr_d;
    logic        discard_q, discard_d;
    logic [63:0] pc_inc;
    logic        xfer;
    logic        accept;
    logic [1:0]  cnt_d;
    logic        buf_space;

`ifdef IFETCH_SKID_EN
    localparam logic [1:0] BUF_CAP = 2'd2;
`else
    localparam logic [1:0] BUF_CAP = 2'd1;
`endif

    // Redirect wins over both the handshake and any response arriving in the same cycle.
    assign pc_inc    = pc_q + 64'(PC_STEP);
    assign xfer      = instr_valid && instr_ready && !redirect_valid;
    assign accept    = (state_q == REQ) && imem_rvalid && !discard_q && !redirect_valid;
    assign buf_space = cnt_d < BUF_CAP;
    assign imem_req  = (state_q == REQ);
    assign imem_addr = addr_q;

`ifdef IFETCH_SKID_EN
    logic [1:0]  cnt_q, cnt_pop;
    logic [31:0] data0_q, data0_d, data1_q, data1_d;
    logic [63:0] bpc0_q, bpc0_d, bpc1_q, bpc1_d;

    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        bpc0_d  = bpc0_q;
        bpc1_d  = bpc1_q;
        cnt_pop = cnt_q;
        if (xfer) begin
            data0_d = data1_q;
            bpc0_d  = bpc1_q;
            cnt_pop = cnt_q - 2'd1;
        end
        if (accept) begin
            if (cnt_pop == 2'd0) begin
                data0_d = imem_rdata;
                bpc0_d  = pc_q;
            end else begin
                data1_d = imem_rdata;
                bpc1_d  = pc_q;
            end
        end
        cnt_d = cnt_pop + {1'b0, accept};
        if (redirect_valid) cnt_d = 2'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            bpc0_q  <= '0;
            bpc1_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            bpc0_q  <= bpc0_d;
            bpc1_q  <= bpc1_d;
        end
    end

    assign instr_valid = (cnt_q != 2'd0);
    assign instr       = data0_q;
    assign instr_pc    = bpc0_q;
`else
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [63:0] bpc_q, bpc_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bpc_d   = bpc_q;
        if (redirect_valid) begin
            valid_d = 1'b0;
        end else begin
            if (xfer) valid_d = 1'b0;
            if (accept) begin
                valid_d = 1'b1;
                data_d  = imem_rdata;
                bpc_d   = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            bpc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            bpc_q   <= bpc_d;
        end
    end

    assign cnt_d       = {1'b0, valid_d};
    assign instr_valid = valid_q;
    assign instr       = data_q;
    assign instr_pc    = bpc_q;
`endif

    // addr_q keeps the in-flight address while pc_q may already hold a redirect target.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    addr_d  = redirect_pc;
                    state_d = REQ;
                end else if (buf_space) begin
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_rvalid) begin
                        discard_d = 1'b0;
                        addr_d    = redirect_pc;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        addr_d    = pc_q;
                    end else begin
                        pc_d   = pc_inc;
                        addr_d = pc_inc;
                    end
                    if (!buf_space) state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: sequential fetch, output stall, redirects, mid-request reset and PC wrap.
module tb_ifetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;

    int vectors     = 0;
    int miscompares = 0;

    ifetch_stage #(.RESET_PC(64'h0), .PC_STEP(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   64'(imem_req),    64'd0);
        chk({tag, "_addr"},  imem_addr,        64'h0);
        chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
        chk({tag, "_instr"}, 64'(instr),       64'd0);
        chk({tag, "_ipc"},   instr_pc,         64'h0);
    endtask

    // Memory answers in the cycle the request is first visible (sampled one edge after req rises).
    task automatic fetch_step(input logic [63:0] a, input logic [31:0] d);
        chk("req_high", 64'(imem_req), 64'd1);
        chk("req_addr", imem_addr, a);
`ifndef IFETCH_SKID_EN
        chk("valid_before", 64'(instr_valid), 64'd0);
`endif
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        chk("instr_valid", 64'(instr_valid), 64'd1);
        chk("instr", 64'(instr), 64'(d));
        chk("instr_pc", instr_pc, a);
`ifndef IFETCH_SKID_EN
        chk("req_gap", 64'(imem_req), 64'd0);
        tick();
`endif
    endtask

    initial begin
        reset          = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        instr_ready    = 1'b1;

        tick();
        check_reset_outputs("rst");
        tick();
        reset = 1'b1;
        tick();

        // sequential fetch
        fetch_step(64'h0, 32'hF84003E9);
        fetch_step(64'h4, 32'h8B020020);
        fetch_step(64'h8, 32'hCB030041);
        fetch_step(64'hC, 32'hF80003E9);

        // decode stalls with CBZ at 0x10
        chk("stall_req_addr", imem_addr, 64'h10);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hB4000116;
        tick();
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(instr_valid), 64'd1);
            chk("stall_instr", 64'(instr), 64'hB4000116);
            chk("stall_pc", instr_pc, 64'h10);
`ifdef IFETCH_SKID_EN
            if (i == 0) begin
                chk("skid_req", 64'(imem_req), 64'd1);
                chk("skid_addr", imem_addr, 64'h14);
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hD2800020;
            end else begin
                chk("skid_req_off", 64'(imem_req), 64'd0);
            end
`else
            chk("stall_req_off", 64'(imem_req), 64'd0);
`endif
            tick();
            imem_rvalid = 1'b0;
        end
        instr_ready = 1'b1;
`ifdef IFETCH_SKID_EN
        tick();
        chk("skid_head_pc", instr_pc, 64'h14);
        chk("skid_head", 64'(instr), 64'hD2800020);
`else
        chk("stall_release", 64'(instr), 64'hB4000116);
        tick();
        fetch_step(64'h14, 32'hD2800020);
`endif
        fetch_step(64'h18, 32'h91000421);
        fetch_step(64'h1C, 32'hAA0203E3);

        // redirect while the request to 0x20 is outstanding; response 3 cycles later
        chk("pre_redir_addr", imem_addr, 64'h20);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("discard_req", 64'(imem_req), 64'd1);
            chk("discard_addr", imem_addr, 64'h20);
            chk("discard_valid", 64'(instr_valid), 64'd0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("dropped_valid", 64'(instr_valid), 64'd0);
        fetch_step(64'h100, 32'h8B1F03E0);

        // redirect together with a response (and, with the FIFO, a transfer)
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h12345678;
        tick();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        chk("rr_valid", 64'(instr_valid), 64'd0);
        chk("rr_req", 64'(imem_req), 64'd1);
        chk("rr_addr", imem_addr, 64'h200);
        chk("rr_req_addr", imem_addr, 64'h200);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hF84083E9;
        tick();
        imem_rvalid = 1'b0;
        chk("rx_valid", 64'(instr_valid), 64'd1);
        chk("rx_pc", instr_pc, 64'h200);
        // redirect in the same cycle decode would accept 0x200
        redirect_valid = 1'b1;
        redirect_pc    = 64'h300;
`ifdef IFETCH_SKID_EN
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BADF00D;
`endif
        tick();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        chk("rx_void_valid", 64'(instr_valid), 64'd0);
        chk("rx_next_addr", imem_addr, 64'h300);
        fetch_step(64'h300, 32'hB4000040);

        // reset while discarding
        redirect_valid = 1'b1;
        redirect_pc    = 64'h400;
        tick();
        redirect_valid = 1'b0;
        chk("prerst_req", 64'(imem_req), 64'd1);
        chk("prerst_addr", imem_addr, 64'h304);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBADBAD00;
        tick();
        check_reset_outputs("stray");
        imem_rvalid = 1'b0;
        reset       = 1'b1;
        tick();
        fetch_step(64'h0, 32'hF84003E9);

        // wrap-around past the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_old_addr", imem_addr, 64'h4);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h55555555;
        tick();
        imem_rvalid = 1'b0;
        chk("wrap_dropped", 64'(instr_valid), 64'd0);
        fetch_step(64'hFFFF_FFFF_FFFF_FFFC, 32'hD65F03C0);
        fetch_step(64'h0, 32'hF84003E9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
